// File: rtl/can_pkg.sv
// Shared CAN constants, receive FSM state type and the single-bit CRC-15 step.
package can_pkg;

  localparam logic [14:0] CRC15_POLY    = 15'h4599;
  localparam logic [14:0] CRC15_INIT    = 15'h0000;
  localparam int          HDR_BITS      = 18;
  localparam int          CRC_BITS      = 15;
  localparam int          MAX_DATA_BITS = 64;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CRC,
    DELIM
  } rx_state_e;

  // One serial CRC-15 update: shift left, fold in the polynomial when the
  // incoming bit differs from the outgoing MSB.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic nxt;
    nxt = b ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (nxt ? CRC15_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_rx_crc_check_if.sv
// Bit-stream and result bundle between the CAN MAC and the receive CRC checker.
interface can_rx_crc_check_if;
  import can_pkg::*;

  logic        i_bit;
  logic        i_bit_valid;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_crc_ok;
  logic        o_crc_err;
  logic        o_form_err;
  logic [14:0] o_crc_calc;
  logic [14:0] o_crc_rx;

  modport master (
    output i_bit, i_bit_valid, i_abort,
    input  o_busy, o_done, o_crc_ok, o_crc_err, o_form_err, o_crc_calc, o_crc_rx
  );

  modport slave (
    input  i_bit, i_bit_valid, i_abort,
    output o_busy, o_done, o_crc_ok, o_crc_err, o_form_err, o_crc_calc, o_crc_rx
  );
endinterface

// File: rtl/can_crc15_serial.sv
// Serial CRC-15 register. Clear and enable together restart the CRC with the
// current bit already folded in.
module can_crc15_serial
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [14:0] crc
);

  logic [14:0] crc_base;

  assign crc_base = clr ? CRC15_INIT : crc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC15_INIT;
    end else if (en) begin
      crc <= crc15_step(crc_base, din);
    end else if (clr) begin
      crc <= CRC15_INIT;
    end
  end

endmodule

// File: rtl/can_rx_crc_check.sv
// CAN 2.0A receive CRC checker: walks SOF..CRC delimiter on destuffed strobes,
// compares the received CRC field with the locally accumulated CRC-15.
module can_rx_crc_check
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  can_rx_crc_check_if.slave    bus
);

  // RTR is the 12th header bit; the down-counter reads HDR_BITS-12 there.
  localparam logic [5:0] RTR_POS  = 6'(HDR_BITS - 12);
  localparam logic [3:0] MAX_DLC  = 4'(MAX_DATA_BITS / 8);

  rx_state_e   state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic        rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d;
  logic [14:0] crc_rx_q, crc_rx_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        form_q, form_d;
  logic        crc_clr, crc_en;
  logic [14:0] crc_calc;
  logic [3:0]  dlc_full, dlc_eff;
  logic [6:0]  data_bits;

  can_crc15_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (bus.i_bit),
    .crc (crc_calc)
  );

  // The last DLC bit arrives with the strobe, so the length uses it directly.
  assign dlc_full  = {dlc_q[2:0], bus.i_bit};
  assign dlc_eff   = (dlc_full > MAX_DLC) ? MAX_DLC : dlc_full;
  assign data_bits = rtr_q ? 7'd0 : {dlc_eff, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rtr_q    <= 1'b0;
      dlc_q    <= '0;
      crc_rx_q <= '0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      form_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rtr_q    <= rtr_d;
      dlc_q    <= dlc_d;
      crc_rx_q <= crc_rx_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      form_q   <= form_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rtr_d    = rtr_q;
    dlc_d    = dlc_q;
    crc_rx_d = crc_rx_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    err_d    = err_q;
    form_d   = form_q;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;

    if (bus.i_abort) begin
      state_d = IDLE;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      form_d  = 1'b0;
    end else if (bus.i_bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.i_bit) begin
            state_d  = HDR;
            count_d  = 6'(HDR_BITS - 1);
            crc_clr  = 1'b1;
            crc_en   = 1'b1;
            crc_rx_d = '0;
            ok_d     = 1'b0;
            err_d    = 1'b0;
            form_d   = 1'b0;
          end
        end
        HDR: begin
          crc_en = 1'b1;
          dlc_d  = dlc_full;
          if (count_q == RTR_POS) rtr_d = bus.i_bit;
          if (count_q == 6'd0) begin
            if (data_bits == 7'd0) begin
              state_d = CRC;
              count_d = 6'(CRC_BITS - 1);
            end else begin
              state_d = DATA;
              count_d = 6'(data_bits - 7'd1);
            end
          end else begin
            count_d = count_q - 6'd1;
          end
        end
        DATA: begin
          crc_en = 1'b1;
          if (count_q == 6'd0) begin
            state_d = CRC;
            count_d = 6'(CRC_BITS - 1);
          end else begin
            count_d = count_q - 6'd1;
          end
        end
        CRC: begin
          crc_rx_d = {crc_rx_q[13:0], bus.i_bit};
          if (count_q == 6'd0) state_d = DELIM;
          else                 count_d = count_q - 6'd1;
        end
        DELIM: begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (crc_rx_q != crc_calc);
          form_d  = !bus.i_bit;
          ok_d    = (crc_rx_q == crc_calc) && bus.i_bit;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = done_q;
  assign bus.o_crc_ok   = ok_q;
  assign bus.o_crc_err  = err_q;
  assign bus.o_form_err = form_q;
  assign bus.o_crc_calc = crc_calc;
  assign bus.o_crc_rx   = crc_rx_q;

endmodule

// File: tb/tb_can_rx_crc_check.sv
// Directed plus randomized frames for can_rx_crc_check against a long-division
// CRC-15 model of the CAN 2.0A frame layout.
module tb_can_rx_crc_check;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic frame_q[$];

  can_rx_crc_check_if bus ();

  can_rx_crc_check dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Standard frame: SOF, ID[10:0], RTR, IDE=0, r0=0, DLC[3:0], data MSB-first.
  task automatic build_frame(input logic [10:0] id, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data);
    int nbits;
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) frame_q.push_back(id[i]);
    frame_q.push_back(rtr);
    frame_q.push_back(1'b0);
    frame_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) frame_q.push_back(dlc[i]);
    nbits = rtr ? 0 : 8 * ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nbits; i++) frame_q.push_back(data[63-i]);
  endtask

  // Remainder of (message * x^15) divided by x^15 + 0x4599.
  function automatic logic [14:0] model_crc();
    int unsigned rem = 0;
    int unsigned b;
    int n = frame_q.size();
    for (int i = 0; i < n + 15; i++) begin
      b = (i < n) ? 32'(frame_q[i]) : 0;
      rem = (rem << 1) | b;
      if (rem[15]) rem = rem ^ 32'h0000_C599;
    end
    return rem[14:0];
  endfunction

  task automatic send_bit(input logic b, input int gap);
    bus.i_bit       = b;
    bus.i_bit_valid = 1'b1;
    @(posedge clk); #1;
    if (gap > 0) begin
      bus.i_bit_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_frame(input logic [14:0] crc_field, input logic delim, input int max_gap);
    foreach (frame_q[i]) send_bit(frame_q[i], int'($urandom_range(max_gap, 0)));
    for (int i = 14; i >= 0; i--) send_bit(crc_field[i], int'($urandom_range(max_gap, 0)));
    send_bit(delim, 0);
    bus.i_bit_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic ok, input logic err,
                              input logic form, input logic [14:0] calc, input logic [14:0] rx);
    check({tag, ".done"},  32'(bus.o_done), 32'd1);
    check({tag, ".busy"},  32'(bus.o_busy), 32'd0);
    check({tag, ".ok"},    32'(bus.o_crc_ok), 32'(ok));
    check({tag, ".err"},   32'(bus.o_crc_err), 32'(err));
    check({tag, ".form"},  32'(bus.o_form_err), 32'(form));
    check({tag, ".calc"},  32'(bus.o_crc_calc), 32'(calc));
    check({tag, ".rx"},    32'(bus.o_crc_rx), 32'(rx));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(bus.o_done), 32'd0);
    check({tag, ".ok_held"},    32'(bus.o_crc_ok), 32'(ok));
  endtask

  initial begin
    logic [14:0] exp_crc;
    logic [63:0] data;
    int          done_seen;

    bus.i_bit       = 1'b1;
    bus.i_bit_valid = 1'b0;
    bus.i_abort     = 1'b0;

    // Reset values
    repeat (2) @(posedge clk); #1;
    check("rst.busy", 32'(bus.o_busy), 32'd0);
    check("rst.done", 32'(bus.o_done), 32'd0);
    check("rst.ok",   32'(bus.o_crc_ok), 32'd0);
    check("rst.err",  32'(bus.o_crc_err), 32'd0);
    check("rst.form", 32'(bus.o_form_err), 32'd0);
    check("rst.calc", 32'(bus.o_crc_calc), 32'd0);
    check("rst.rx",   32'(bus.o_crc_rx), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Recessive bits in IDLE are not a SOF
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    bus.i_bit_valid = 1'b0;
    check("idle_recessive.busy", 32'(bus.o_busy), 32'd0);

    // SOF raises busy one cycle later
    build_frame(11'h000, 1'b0, 4'd0, 64'd0);
    send_bit(1'b0, 0);
    bus.i_bit_valid = 1'b0;
    check("sof.busy", 32'(bus.o_busy), 32'd1);
    void'(frame_q.pop_front());
    send_frame(15'h0000, 1'b1, 0);
    check_result("all_dominant", 1'b1, 1'b0, 1'b0, 15'h0000, 15'h0000);

    // ID 0x001, DLC 0: reference CRC is 0x2213
    build_frame(11'h001, 1'b0, 4'd0, 64'd0);
    check("id1.model", 32'(model_crc()), 32'h2213);
    send_frame(15'h2213, 1'b1, 0);
    check_result("id1_ok", 1'b1, 1'b0, 1'b0, 15'h2213, 15'h2213);
    send_frame(15'h2212, 1'b1, 1);
    check_result("id1_crc_err", 1'b0, 1'b1, 1'b0, 15'h2213, 15'h2212);
    send_frame(15'h2213, 1'b0, 0);
    check_result("id1_form_err", 1'b0, 1'b0, 1'b1, 15'h2213, 15'h2213);

    // Random 8-byte frames (83 CRC-covered bits), gapped strobes
    for (int n = 0; n < 4; n++) begin
      data = {$urandom, $urandom};
      build_frame(11'($urandom), 1'b0, 4'd8, data);
      exp_crc = model_crc();
      send_frame(exp_crc, 1'b1, 5);
      check_result($sformatf("rand8_%0d", n), 1'b1, 1'b0, 1'b0, exp_crc, exp_crc);
    end

    // Random frame with one corrupted CRC bit
    data = {$urandom, $urandom};
    build_frame(11'($urandom), 1'b0, 4'(1 + $urandom_range(7, 0)), data);
    exp_crc = model_crc();
    send_frame(exp_crc ^ (15'h1 << $urandom_range(14, 0)), 1'b1, 2);
    check("rand_bad.err", 32'(bus.o_crc_err), 32'd1);
    check("rand_bad.ok",  32'(bus.o_crc_ok), 32'd0);
    @(posedge clk); #1;

    // RTR with DLC 8 carries no data
    build_frame(11'h5A5, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_crc = model_crc();
    send_frame(exp_crc, 1'b1, 1);
    check_result("rtr_dlc8", 1'b1, 1'b0, 1'b0, exp_crc, exp_crc);

    // DLC 12 is clamped to 64 data bits
    data = {$urandom, $urandom};
    build_frame(11'h123, 1'b0, 4'd12, data);
    check("dlc12.len", 32'(frame_q.size()), 32'd83);
    exp_crc = model_crc();
    send_frame(exp_crc, 1'b1, 3);
    check_result("dlc12", 1'b1, 1'b0, 1'b0, exp_crc, exp_crc);

    // Abort mid-DATA with a coincident strobe, then a clean frame
    build_frame(11'h2AA, 1'b0, 4'd8, {$urandom, $urandom});
    for (int i = 0; i < 39; i++) send_bit(frame_q[i], int'($urandom_range(1, 0)));
    bus.i_abort = 1'b1;
    send_bit(frame_q[39], 0);
    bus.i_abort     = 1'b0;
    bus.i_bit_valid = 1'b0;
    check("abort.busy", 32'(bus.o_busy), 32'd0);
    check("abort.ok",   32'(bus.o_crc_ok), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done) done_seen++;
      @(posedge clk); #1;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    data = {$urandom, $urandom};
    build_frame(11'($urandom), 1'b0, 4'd5, data);
    exp_crc = model_crc();
    send_frame(exp_crc, 1'b1, 2);
    check_result("after_abort", 1'b1, 1'b0, 1'b0, exp_crc, exp_crc);

    // Asynchronous reset mid-CRC field clears outputs without a clock edge
    build_frame(11'h7FF, 1'b0, 4'd2, {$urandom, $urandom});
    exp_crc = model_crc();
    foreach (frame_q[i]) send_bit(frame_q[i], 0);
    for (int i = 14; i >= 8; i--) send_bit(exp_crc[i], 0);
    bus.i_bit_valid = 1'b0;
    check("pre_rst.busy", 32'(bus.o_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst.busy", 32'(bus.o_busy), 32'd0);
    check("async_rst.calc", 32'(bus.o_crc_calc), 32'd0);
    check("async_rst.rx",   32'(bus.o_crc_rx), 32'd0);
    check("async_rst.done", 32'(bus.o_done), 32'd0);
    check("async_rst.flags", {29'd0, bus.o_crc_ok, bus.o_crc_err, bus.o_form_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Recovery after reset
    build_frame(11'h0F0, 1'b0, 4'd1, {$urandom, $urandom});
    exp_crc = model_crc();
    send_frame(exp_crc, 1'b1, 0);
    check_result("post_rst", 1'b1, 1'b0, 1'b0, exp_crc, exp_crc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_rx_crc_check.md
# can_rx_crc_check

Receive-side CRC checker for CAN 2.0A (standard, 11-bit ID) frames: the counterpart of the parallel CRC15 generator on the transmit path. It consumes the destuffed serial bit stream one bit per strobe and tracks frame fields from SOF through the CRC delimiter. It accumulates CRC-15 serially over SOF..data, captures the received 15-bit CRC field, and reports match/mismatch and delimiter form errors to the CAN MAC.

## Interface
- No parameters; polynomial 0x4599, init 0x0000, 8-byte data cap are fixed constants.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_bit  in  1  destuffed bus bit (0 = dominant)
- i_bit_valid  in  1  one-cycle strobe: i_bit is a new destuffed bit (stuff bits never strobed)
- i_abort  in  1  MAC error/bus-off: abandon current frame
- o_busy  out  1  frame in progress (state != IDLE)
- o_done  out  1  one-cycle pulse: check complete
- o_crc_ok  out  1  valid with o_done: received CRC == calculated and delimiter recessive
- o_crc_err  out  1  valid with o_done: CRC mismatch
- o_form_err  out  1  valid with o_done: CRC delimiter dominant
- o_crc_calc  out  15  calculated CRC, held until next SOF
- o_crc_rx  out  15  received CRC field, held until next SOF

## Operation
- States: IDLE, HDR, DATA, CRC, DELIM.
- IDLE: on i_bit_valid && i_bit==0 (SOF): clear CRC/count, fold the SOF bit into the CRC, go to HDR. Recessive bits ignored.
- HDR: 18 bits (ID[10:0], RTR, IDE, r0, DLC[3:0]), all folded into CRC. Latch RTR and DLC. After the last DLC bit: data_bits = 0 if RTR=1, else 8*min(DLC,8). Go to DATA, or to CRC if data_bits==0.
- DATA: data_bits bits folded into CRC, then CRC.
- CRC: 15 bits shifted MSB-first into crc_rx, not folded. Then DELIM.
- DELIM: 1 bit. Latch results, pulse o_done, go to IDLE.
- Serial CRC per bit b: nxt = b ^ crc[14]; crc = {crc[13:0],1'b0}; if nxt, crc ^= 15'h4599.
- IDE=1 is not supported and is not flagged here; the MAC handles it. The count still follows the standard layout.
- A single 6-bit down-counter covers fields (max 64 data bits). Field ends when count==0 on a valid bit.
- Results: o_crc_err = (crc_rx != crc_calc); o_form_err = (delimiter==0); o_crc_ok = !crc_err && !form_err.

## Timing
- Reset values: state IDLE, o_busy 0, o_done 0, o_crc_ok 0, o_crc_err 0, o_form_err 0, o_crc_calc 0, o_crc_rx 0.
- Any state advances only on i_bit_valid; between strobes, state and registers hold.
- Strobes may arrive on back-to-back cycles.
- o_done is registered: it is high the cycle after the delimiter strobe. Flags are valid in that same cycle and held until the next SOF clears them.
- o_busy goes high the cycle after the SOF strobe and low the same cycle o_done rises.
- i_abort has priority over i_bit_valid in the same cycle. It forces IDLE next cycle with no o_done and leaves the flags cleared. A strobe coinciding with abort is dropped.
- Mid-frame async rst: immediate return to reset values.
- DLC 9..15 is treated as 8 bytes.

## Structure
- Shared package can_pkg holds: CRC15_POLY = 15'h4599, CRC15_INIT = 15'h0, HDR_BITS = 18, CRC_BITS = 15, MAX_DATA_BITS = 64, and the state enum.
- One sub-module, can_crc15_serial: per-bit CRC update with clear and enable. The transmit-side serial path reuses it.

## Test plan
- All-dominant header (ID 0x000, DLC 0) + CRC 0x0000 + delimiter 1 -> o_done, o_crc_ok=1, o_crc_calc=0x0000.
- ID 0x001, RTR 0, DLC 0, CRC field 0x2213, delimiter 1 -> o_crc_ok=1, o_crc_calc=0x2213. Same frame with CRC field 0x2212 -> o_crc_err=1, o_crc_rx=0x2212.
- Same frame with a dominant delimiter -> o_form_err=1, o_crc_ok=0.
- 8-byte data frames bit-matched against the parallel CRC15 generator output (83-bit vectors), with strobes gapped randomly 0-5 idle cycles -> o_crc_calc equals the generator CRC, o_crc_ok=1.
- RTR=1 with DLC=8 -> no data bits consumed, CRC field expected right after DLC. DLC=12 data frame -> exactly 64 data bits.
- i_abort asserted mid-DATA, then a new valid frame -> no o_done for the aborted frame, correct result for the second. Async rst asserted mid-CRC -> all outputs 0 immediately.
